// File: rtl/reg_serial_reader.sv
// ============================================================================
// reg_serial_reader
//
// Bit-serial read-out port for the register bank. A parallel word is captured
// on a load handshake and then shifted out LSB first, one bit per accepted
// beat, under a valid/ready handshake on the serial side.
//
// Optional feature (compile-time macro REG_SERIAL_PARITY_EN):
//   defined   - an even-parity beat (XOR of the captured word) follows data
//               bit WIDTH-1; a word takes WIDTH+1 beats.
//   undefined - no parity logic; a word takes WIDTH beats.
//
// Parameters:
//   WIDTH       data bits per word (2..32)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   load_valid  load_data is presented for capture
//   load_ready  block can accept a word (IDLE)
//   load_data   parallel word from the register bank
//   ser_out     current serial bit
//   ser_valid   ser_out holds a valid bit (SHIFT)
//   ser_ready   consumer accepts ser_out this cycle
//   ser_last    current beat is the final beat of the word
//   busy        a word is being shifted out
// ============================================================================
module reg_serial_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

`ifdef REG_SERIAL_PARITY_EN
    localparam int BEATS = WIDTH + 1;
`else
    localparam int BEATS = WIDTH;
`endif
    // Sized so the count can reach BEATS after the final beat without wrapping.
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    count_reg;
    logic             load_fire;
    logic             beat_fire;
    logic             last_beat;
    logic             data_bit;

    // Handshakes are decoded from registered state only, so no input ever
    // reaches an output combinationally.
    assign load_fire = load_valid && (state_reg == IDLE);
    assign beat_fire = ser_ready && (state_reg == SHIFT);
    assign last_beat = (count_reg == CW'(BEATS - 1));

`ifdef REG_SERIAL_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (load_fire) begin
            parity_reg <= ^load_data;
        end
    end

    // Once all data bits have been sent the count sits at WIDTH, which is the
    // parity beat; the shift register is all zeros by then.
    assign data_bit = (count_reg == CW'(WIDTH)) ? parity_reg : shift_reg[0];
`else
    assign data_bit = shift_reg[0];
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load_fire) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (beat_fire && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    always_comb begin
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        busy       = 1'b0;
        ser_last   = 1'b0;
        ser_out    = 1'b0;
        case (state_reg)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_last  = last_beat;
                ser_out   = data_bit;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: capture on load, shift right with zero fill on each beat.
    // Both hold on a stall, so nothing is lost or repeated.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            count_reg <= '0;
        end else if (load_fire) begin
            shift_reg <= load_data;
            count_reg <= '0;
        end else if (beat_fire) begin
            shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule
